// File: rtl/mul_share_arbiter.sv
// Round-robin front end sharing one 8x8 ripple-array multiplier between NUM_REQ requesters.
// Optional per-requester completion counters: define MUL_SHARE_ARBITER_STATS_EN.
module mul_share_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned CALC_CYCLES = 2,
    parameter int unsigned ID_W        = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [8*NUM_REQ-1:0]    req_a,
    input  logic [8*NUM_REQ-1:0]    req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [15:0]             rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy,
    output logic [16*NUM_REQ-1:0]   stat_count
);

    localparam int unsigned CNT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
    localparam int unsigned SEL_W = ID_W + 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_op_a;
    logic [7:0]         r_op_b;
    logic [ID_W-1:0]    r_op_id;
    logic [ID_W-1:0]    r_last_grant;
    logic               r_rsp_valid;
    logic [15:0]        r_rsp_data;
    logic [ID_W-1:0]    r_rsp_id;

    logic               w_grant_vld;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_can_accept;
    logic               w_accept;
    logic [SEL_W-1:0]   w_sel_base;
    logic [7:0]         w_sel_a;
    logic [7:0]         w_sel_b;
    logic [15:0]        w_product;

    // Shift-and-add array built from explicit full-adder ripple rows.
    function automatic logic [15:0] ripple_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        logic [15:0] pp;
        logic        carry;
        logic        sum;
        acc = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            pp    = {8'h00, a & {8{b[i]}}} << i;
            carry = 1'b0;
            for (int unsigned j = 0; j < 16; j++) begin
                sum    = acc[j] ^ pp[j] ^ carry;
                carry  = (acc[j] & pp[j]) | (carry & (acc[j] ^ pp[j]));
                acc[j] = sum;
            end
        end
        return acc;
    endfunction

    // First valid requester at or after last_grant+1, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [ID_W-1:0]    last);
        logic            found;
        logic [ID_W-1:0] sel;
        int unsigned     idx;
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(last) + 32'd1 + k) % NUM_REQ;
            if (!found && vld[ID_W'(idx)]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end
        end
        return {found, sel};
    endfunction

    assign {w_grant_vld, w_grant_idx} = rr_pick(req_valid, r_last_grant);

    // Reset gates the grant so req_ready reads zero while rst_n is low.
    assign w_can_accept = rst_n && ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready));
    assign w_accept     = w_can_accept && w_grant_vld;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_sel_base = {w_grant_idx, 3'b000};
    assign w_sel_a    = req_a[w_sel_base +: 8];
    assign w_sel_b    = req_b[w_sel_base +: 8];

    // Fed only from the held operand registers: a CALC_CYCLES multicycle path.
    assign w_product = ripple_mul(r_op_a, r_op_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_id      <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_id     <= '0;
        end else begin
            if (w_accept) begin
                r_op_a       <= w_sel_a;
                r_op_b       <= w_sel_b;
                r_op_id      <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_CALC;
                        r_cnt   <= CNT_W'(CALC_CYCLES - 1);
                    end
                end
                S_CALC: begin
                    if (r_cnt == '0) begin
                        r_rsp_data  <= w_product;
                        r_rsp_id    <= r_op_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (w_accept) begin
                            r_state <= S_CALC;
                            r_cnt   <= CNT_W'(CALC_CYCLES - 1);
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != S_IDLE);

`ifdef MUL_SHARE_ARBITER_STATS_EN
    logic [15:0] r_stat [NUM_REQ];

    // One wrapping counter per requester, bumped on each response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_stat[i] <= '0;
            end
        end else if (r_rsp_valid && rsp_ready) begin
            r_stat[r_rsp_id] <= r_stat[r_rsp_id] + 16'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        assign stat_count[16*gi +: 16] = r_stat[gi];
    end
`else
    assign stat_count = '0;
`endif

endmodule
